// File: rtl/ysyx_23060187_arbiter_if.sv
// ysyx_23060187_arbiter_if: bus bundle between the IFU, the LSU, the shared memory port and the arbiter.
// Requester side: ifu_req_valid/ready, ifu_addr, ifu_resp_valid, ifu_rdata and
//   lsu_req_valid/ready, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_resp_valid, lsu_rdata.
// Memory side: mem_req_valid/ready, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_resp_valid, mem_rdata.
// owner: requester of the current or last grant (0 = IFU, 1 = LSU).
// slave is the arbiter's view; master is the view of the requesters plus memory around it.
interface ysyx_23060187_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_resp_valid;
  logic [DATA_W-1:0] ifu_rdata;
  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_addr;
  logic              lsu_wen;
  logic [DATA_W-1:0] lsu_wdata;
  logic [7:0]        lsu_wmask;
  logic              lsu_resp_valid;
  logic [DATA_W-1:0] lsu_rdata;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [7:0]        mem_wmask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_rdata;
  logic              owner;
  modport slave (
    input  ifu_req_valid, ifu_addr, lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
           mem_req_ready, mem_resp_valid, mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, lsu_req_ready, lsu_resp_valid, lsu_rdata,
           mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, owner
  );
  modport master (
    output ifu_req_valid, ifu_addr, lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
           mem_req_ready, mem_resp_valid, mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, lsu_req_ready, lsu_resp_valid, lsu_rdata,
           mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, owner
  );
endinterface

// File: rtl/ysyx_23060187_arbiter.sv
// ysyx_23060187_arbiter: round-robin arbiter sharing one memory port between IFU and LSU, one transaction in flight.
// Ports: clk (rising edge), rst (asynchronous, active low), bus (ysyx_23060187_arbiter_if.slave).
module ysyx_23060187_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic                    clk,
  input logic                    rst,
  ysyx_23060187_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t            state, state_nx;
  logic              last_grant, owner_q, wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        wmask_q;
  logic              grant, pick_lsu, ack;
  // Grants and responses are gated by state and reset so that every output is 0 while rst is low.
  always_comb begin
    pick_lsu           = bus.lsu_req_valid & (~bus.ifu_req_valid | ~last_grant);
    grant              = rst & (state == IDLE) & (bus.ifu_req_valid | bus.lsu_req_valid);
    ack                = (state == WAIT) & bus.mem_resp_valid;
    state_nx           = grant ? ISSUE : (state == ISSUE && bus.mem_req_ready) ? WAIT : ack ? IDLE : state;
    bus.ifu_req_ready  = grant & ~pick_lsu;
    bus.lsu_req_ready  = grant & pick_lsu;
    bus.mem_req_valid  = state == ISSUE;
    bus.mem_addr       = addr_q;
    bus.mem_wen        = wen_q;
    bus.mem_wdata      = wdata_q;
    bus.mem_wmask      = wmask_q;
    bus.ifu_resp_valid = ack & ~owner_q;
    bus.lsu_resp_valid = ack & owner_q;
    bus.ifu_rdata      = (ack & ~owner_q) ? bus.mem_rdata : '0;
    bus.lsu_rdata      = (ack & owner_q) ? bus.mem_rdata : '0;
    bus.owner          = owner_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end
  // Request fields are captured at the grant so a requester may drop valid once accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
      owner_q    <= 1'b0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
    end else if (grant) begin
      last_grant <= pick_lsu;
      owner_q    <= pick_lsu;
      addr_q     <= pick_lsu ? bus.lsu_addr : bus.ifu_addr;
      wen_q      <= pick_lsu & bus.lsu_wen;
      wdata_q    <= pick_lsu ? bus.lsu_wdata : '0;
      wmask_q    <= pick_lsu ? bus.lsu_wmask : '0;
    end
  end
endmodule

// File: tb/tb_ysyx_23060187_arbiter.sv
// tb_ysyx_23060187_arbiter: scoreboard bench for the IFU/LSU memory arbiter.
module tb_ysyx_23060187_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ysyx_23060187_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  ysyx_23060187_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {
    logic        who;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic mon_who;
  logic [31:0] mon_d;
  int errs = 0;
  int checks = 0;
  function automatic logic [142:0] outs();
    return {bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_resp_valid, bus.lsu_resp_valid,
            bus.ifu_rdata, bus.lsu_rdata, bus.mem_req_valid, bus.mem_addr, bus.mem_wen,
            bus.mem_wdata, bus.mem_wmask, bus.owner};
  endfunction
  always @(negedge clk) begin
    checks++;
    if ((!bus.ifu_resp_valid && bus.ifu_rdata !== 32'h0) || (!bus.lsu_resp_valid && bus.lsu_rdata !== 32'h0)) begin
      errs++;
      $display("FAIL rdata_gating ifu_rdata=%h lsu_rdata=%h required 0 when resp_valid low", bus.ifu_rdata, bus.lsu_rdata);
    end
    if (bus.ifu_req_ready || bus.lsu_req_ready) begin
      checks++;
      if (bus.ifu_req_ready && bus.lsu_req_ready) begin
        errs++;
        $display("FAIL ready_overlap got both readys=1 required at most one");
      end
    end
    if (bus.ifu_resp_valid || bus.lsu_resp_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errs++;
        $display("FAIL resp_unexpected ifu_resp_valid=%b lsu_resp_valid=%b required no response", bus.ifu_resp_valid, bus.lsu_resp_valid);
      end else begin
        mon_e   = sb.pop_front();
        mon_who = bus.lsu_resp_valid;
        mon_d   = mon_who ? bus.lsu_rdata : bus.ifu_rdata;
        if ((bus.ifu_resp_valid && bus.lsu_resp_valid) || mon_who !== mon_e.who || mon_d !== mon_e.data) begin
          errs++;
          $display("FAIL resp_route got who=%b data=%h (both=%b) required who=%b data=%h",
                   mon_who, mon_d, bus.ifu_resp_valid & bus.lsu_resp_valid, mon_e.who, mon_e.data);
        end
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    bus.ifu_req_valid  = 1'b0;
    bus.ifu_addr       = 32'h0;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_addr       = 32'h0;
    bus.lsu_wen        = 1'b0;
    bus.lsu_wdata      = 32'h0;
    bus.lsu_wmask      = 8'h0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = 32'h0;
  endtask
  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
  endtask
  task automatic mem_serve(input logic [31:0] d);
    int n = 0;
    while (bus.mem_req_valid !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    checks++;
    if (bus.mem_req_valid !== 1'b1) begin
      errs++;
      $display("FAIL mem_serve_timeout mem_req_valid=%b required 1 within 20 cycles", bus.mem_req_valid);
      return;
    end
    bus.mem_req_ready  = 1'b1;
    cyc();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = d;
    cyc();
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = 32'h0;
  endtask
  task automatic test_reset();
    idle_inputs();
    bus.ifu_req_valid  = 1'b1;
    bus.lsu_req_valid  = 1'b1;
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b1;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (outs() !== '0) begin
      errs++;
      $display("FAIL reset_outputs got %h required 0", outs());
    end
    idle_inputs();
    cyc();
    rst = 1'b1;
    cyc();
  endtask
  task automatic test_ifu_fetch();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h80000000;
    bus.mem_req_ready = 1'b1;
    sb.push_back({1'b0, 32'h00100073});
    #1;
    checks++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b10) begin
      errs++;
      $display("FAIL ifu_accept got readys=%b required 10", {bus.ifu_req_ready, bus.lsu_req_ready});
    end
    cyc();
    bus.ifu_req_valid = 1'b0;
    bus.ifu_addr      = 32'h0;
    #1;
    checks++;
    if ({bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wmask, bus.owner} !== {1'b1, 32'h80000000, 1'b0, 8'h0, 1'b0}) begin
      errs++;
      $display("FAIL ifu_issue got valid=%b addr=%h wen=%b wmask=%h owner=%b required 1 80000000 0 00 0",
               bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wmask, bus.owner);
    end
    cyc();
    bus.mem_req_ready = 1'b0;
    #1;
    checks++;
    if ({bus.mem_req_valid, bus.ifu_resp_valid} !== 2'b00) begin
      errs++;
      $display("FAIL ifu_wait got mem_req_valid=%b ifu_resp_valid=%b required 0 0", bus.mem_req_valid, bus.ifu_resp_valid);
    end
    cyc();
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h00100073;
    #1;
    checks++;
    if ({bus.ifu_resp_valid, bus.ifu_rdata, bus.lsu_resp_valid} !== {1'b1, 32'h00100073, 1'b0}) begin
      errs++;
      $display("FAIL ifu_resp got valid=%b rdata=%h lsu_valid=%b required 1 00100073 0",
               bus.ifu_resp_valid, bus.ifu_rdata, bus.lsu_resp_valid);
    end
    cyc();
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = 32'h0;
    checks++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL ifu_drain got %0d pending required 0", sb.size());
    end
  endtask
  task automatic test_round_robin();
    do_reset();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h80000004;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h80002000;
    #1;
    checks++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b10) begin
      errs++;
      $display("FAIL rr_first got readys=%b required 10", {bus.ifu_req_ready, bus.lsu_req_ready});
    end
    sb.push_back({1'b0, 32'h11111111});
    cyc();
    #1;
    checks++;
    if (bus.owner !== 1'b0) begin
      errs++;
      $display("FAIL rr_owner0 got %b required 0", bus.owner);
    end
    mem_serve(32'h11111111);
    #1;
    checks++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b01) begin
      errs++;
      $display("FAIL rr_second got readys=%b required 01", {bus.ifu_req_ready, bus.lsu_req_ready});
    end
    sb.push_back({1'b1, 32'h22222222});
    cyc();
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    #1;
    checks++;
    if ({bus.owner, bus.mem_addr} !== {1'b1, 32'h80002000}) begin
      errs++;
      $display("FAIL rr_owner1 got owner=%b addr=%h required 1 80002000", bus.owner, bus.mem_addr);
    end
    mem_serve(32'h22222222);
    checks++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL rr_drain got %0d pending required 0", sb.size());
    end
  endtask
  task automatic test_store_backpressure();
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h80001000;
    bus.lsu_wen       = 1'b1;
    bus.lsu_wdata     = 32'hDEADBEEF;
    bus.lsu_wmask     = 8'h0F;
    #1;
    checks++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b01) begin
      errs++;
      $display("FAIL st_accept got readys=%b required 01", {bus.ifu_req_ready, bus.lsu_req_ready});
    end
    sb.push_back({1'b1, 32'h12345678});
    cyc();
    bus.lsu_req_valid = 1'b0;
    bus.lsu_addr      = 32'h55555555;
    bus.lsu_wen       = 1'b0;
    bus.lsu_wdata     = 32'h0;
    bus.lsu_wmask     = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      bus.mem_req_ready = (i == 3);
      #1;
      checks++;
      if ({bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask} !== {1'b1, 32'h80001000, 1'b1, 32'hDEADBEEF, 8'h0F}) begin
        errs++;
        $display("FAIL st_hold%0d got valid=%b addr=%h wen=%b wdata=%h wmask=%h required 1 80001000 1 deadbeef 0f",
                 i, bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask);
      end
      cyc();
    end
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h12345678;
    #1;
    checks++;
    if ({bus.mem_req_valid, bus.lsu_resp_valid, bus.lsu_rdata, bus.ifu_resp_valid} !== {1'b0, 1'b1, 32'h12345678, 1'b0}) begin
      errs++;
      $display("FAIL st_resp got mem_req_valid=%b lsu_valid=%b rdata=%h ifu_valid=%b required 0 1 12345678 0",
               bus.mem_req_valid, bus.lsu_resp_valid, bus.lsu_rdata, bus.ifu_resp_valid);
    end
    cyc();
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = 32'h0;
    #1;
    checks++;
    if (bus.lsu_resp_valid !== 1'b0) begin
      errs++;
      $display("FAIL st_pulse got lsu_resp_valid=%b required 0", bus.lsu_resp_valid);
    end
  endtask
  task automatic test_spurious();
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'hBAD0BAD0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({bus.ifu_resp_valid, bus.lsu_resp_valid, bus.mem_req_valid} !== 3'b000) begin
        errs++;
        $display("FAIL spur_idle%0d got resp=%b%b mem_req_valid=%b required 000",
                 i, bus.ifu_resp_valid, bus.lsu_resp_valid, bus.mem_req_valid);
      end
      cyc();
    end
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h80000020;
    #1;
    checks++;
    if (bus.ifu_req_ready !== 1'b1) begin
      errs++;
      $display("FAIL spur_accept got ifu_req_ready=%b required 1", bus.ifu_req_ready);
    end
    sb.push_back({1'b0, 32'h00000013});
    cyc();
    bus.ifu_req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({bus.mem_req_valid, bus.ifu_resp_valid, bus.lsu_resp_valid, bus.mem_addr} !== {3'b100, 32'h80000020}) begin
        errs++;
        $display("FAIL spur_issue%0d got mem_req_valid=%b resp=%b%b addr=%h required 1 00 80000020",
                 i, bus.mem_req_valid, bus.ifu_resp_valid, bus.lsu_resp_valid, bus.mem_addr);
      end
      cyc();
    end
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = 32'h0;
    mem_serve(32'h00000013);
    checks++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL spur_drain got %0d pending required 0", sb.size());
    end
  endtask
  task automatic test_reset_mid();
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h80003000;
    bus.lsu_wen       = 1'b0;
    bus.mem_req_ready = 1'b1;
    #1;
    checks++;
    if (bus.lsu_req_ready !== 1'b1) begin
      errs++;
      $display("FAIL rm_accept got lsu_req_ready=%b required 1", bus.lsu_req_ready);
    end
    cyc();
    bus.lsu_req_valid = 1'b0;
    cyc();
    bus.mem_req_ready = 1'b0;
    #1 rst = 1'b0;
    #1;
    checks++;
    if (outs() !== '0) begin
      errs++;
      $display("FAIL rm_outputs got %h required 0", outs());
    end
    cyc();
    rst = 1'b1;
    cyc();
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'hCAFEF00D;
    #1;
    checks++;
    if ({bus.ifu_resp_valid, bus.lsu_resp_valid} !== 2'b00) begin
      errs++;
      $display("FAIL rm_late_resp got resp=%b%b required 00", bus.ifu_resp_valid, bus.lsu_resp_valid);
    end
    cyc();
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = 32'h0;
    bus.ifu_req_valid  = 1'b1;
    bus.ifu_addr       = 32'h80000010;
    #1;
    checks++;
    if (bus.ifu_req_ready !== 1'b1) begin
      errs++;
      $display("FAIL rm_fresh_accept got ifu_req_ready=%b required 1", bus.ifu_req_ready);
    end
    sb.push_back({1'b0, 32'h01234567});
    cyc();
    bus.ifu_req_valid = 1'b0;
    mem_serve(32'h01234567);
    checks++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL rm_drain got %0d pending required 0", sb.size());
    end
  endtask
  task automatic test_back_to_back();
    logic        mdl_last;
    logic        exp_lsu;
    logic        exp_wen;
    logic [31:0] d;
    do_reset();
    mdl_last          = 1'b1;
    bus.ifu_req_valid = 1'b1;
    bus.lsu_req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.ifu_addr  = 32'h80000000 + 32'(i * 4);
      bus.lsu_addr  = 32'h80004000 + 32'(i * 4);
      bus.lsu_wen   = 1'($urandom_range(1));
      bus.lsu_wdata = $urandom;
      bus.lsu_wmask = 8'hFF;
      exp_lsu       = ~mdl_last;
      exp_wen       = exp_lsu & bus.lsu_wen;
      d             = $urandom;
      #1;
      checks++;
      if ({bus.ifu_req_ready, bus.lsu_req_ready} !== {~exp_lsu, exp_lsu}) begin
        errs++;
        $display("FAIL b2b_grant%0d got readys=%b required %b", i, {bus.ifu_req_ready, bus.lsu_req_ready}, {~exp_lsu, exp_lsu});
      end
      sb.push_back({exp_lsu, d});
      mdl_last = exp_lsu;
      cyc();
      #1;
      checks++;
      if ({bus.owner, bus.mem_addr, bus.mem_wen} !== {exp_lsu, exp_lsu ? 32'h80004000 + 32'(i * 4) : 32'h80000000 + 32'(i * 4), exp_wen}) begin
        errs++;
        $display("FAIL b2b_issue%0d got owner=%b addr=%h wen=%b required %b %h %b", i, bus.owner, bus.mem_addr, bus.mem_wen,
                 exp_lsu, exp_lsu ? 32'h80004000 + 32'(i * 4) : 32'h80000000 + 32'(i * 4), exp_wen);
      end
      mem_serve(d);
    end
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    cyc();
    checks++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL b2b_drain got %0d pending required 0", sb.size());
    end
  endtask
  initial begin
    test_reset();
    test_ifu_fetch();
    test_round_robin();
    test_store_backpressure();
    test_spurious();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish within 100000 time units");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ysyx_23060187_arbiter.md
YSYX_23060187_ARBITER -- requirements
Module: ysyx_23060187_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the address width of all ports.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width of all ports.
REQ-003 Port clk, input, 1: SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: SHALL be the asynchronous, active-low reset.
REQ-005 Port ifu_req_valid, input, 1: SHALL indicate an instruction-fetch read request.
REQ-006 Port ifu_req_ready, output, 1: SHALL indicate the IFU request is accepted this cycle.
REQ-007 Port ifu_addr, input, ADDR_W: SHALL carry the fetch address.
REQ-008 Port ifu_resp_valid, output, 1: SHALL indicate that ifu_rdata is valid.
REQ-009 Port ifu_rdata, output, DATA_W: SHALL carry the fetched instruction word.
REQ-010 Port lsu_req_valid, input, 1: SHALL indicate a load/store request.
REQ-011 Port lsu_req_ready, output, 1: SHALL indicate the LSU request is accepted this cycle.
REQ-012 Ports lsu_addr (ADDR_W), lsu_wen (1), lsu_wdata (DATA_W), lsu_wmask (8), all inputs: SHALL carry the LSU request fields.
REQ-013 Ports lsu_resp_valid (1) and lsu_rdata (DATA_W), outputs: SHALL carry the LSU response; a response is also returned for stores.
REQ-014 Ports mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask (8), outputs: SHALL form the single shared memory request.
REQ-015 Port mem_req_ready, input, 1: SHALL indicate that memory accepts the request.
REQ-016 Ports mem_resp_valid (1) and mem_rdata (DATA_W), inputs: SHALL carry the memory response.
REQ-017 Port owner, output, 1: SHALL hold the owner of the current or last grant (0 = IFU, 1 = LSU).

Function
REQ-018 The FSM SHALL have three states: IDLE, ISSUE and WAIT. Exactly one transaction SHALL be outstanding at a time.
REQ-019 IDLE, one requester valid: the FSM SHALL grant it, pulse its req_ready in that same cycle, latch its fields, and go to ISSUE.
REQ-020 IDLE, both valid: the FSM SHALL grant the requester that is not equal to last_grant (round-robin).
REQ-021 last_grant SHALL update on every grant.
REQ-022 An IFU grant SHALL latch mem_wen=0, mem_wmask=0 and mem_wdata=0.
REQ-023 ISSUE: mem_req_valid SHALL be 1, with the latched fields held stable.
REQ-024 ISSUE with mem_req_ready=1: the FSM SHALL go to WAIT on the next edge.
REQ-025 ISSUE with mem_req_ready=0: the FSM SHALL remain in ISSUE, with no timeout.
REQ-026 WAIT: mem_req_valid SHALL be 0.
REQ-027 WAIT with mem_resp_valid=1: the owner's resp_valid SHALL equal 1 combinationally, its rdata SHALL equal mem_rdata, and the FSM SHALL go to IDLE on the next edge.
REQ-028 The non-owner's resp_valid SHALL be 0 at all times.
REQ-029 mem_resp_valid outside WAIT SHALL be ignored.
REQ-030 ifu_req_ready and lsu_req_ready SHALL be 0 outside IDLE and SHALL never both be 1.
REQ-031 Minimum transaction latency: accept at cycle T, mem_req_valid at T+1, response no earlier than T+2, next accept no earlier than T+3.
REQ-032 A requester deasserting valid after acceptance SHALL NOT affect the transaction in flight.
REQ-033 mem_rdata SHALL be passed through unmodified; the LSU performs byte/half extraction.
REQ-034 ifu_rdata and lsu_rdata SHALL be 0 whenever the corresponding resp_valid is 0.

Reset
REQ-035 rst=0 SHALL asynchronously force state=IDLE, last_grant=1 (IFU wins the first tie), owner=0, and all latched fields to 0.
REQ-036 While rst=0, all outputs SHALL be 0.
REQ-037 Reset mid-transaction SHALL abandon it; no response SHALL be delivered to either requester.
REQ-038 After rst returns to 1, operation SHALL resume from IDLE on the next edge.

Verification
REQ-039 IFU only, ifu_addr=0x80000000, mem_req_ready=1, response after 2 cycles with mem_rdata=0x00100073 -> ifu_req_ready pulse at T; mem_addr=0x80000000, mem_wen=0 at T+1; ifu_resp_valid=1 with ifu_rdata=0x00100073; lsu_resp_valid=0 throughout.
REQ-040 Both requesters valid after reset, held through two grants -> IFU granted first, then LSU; owner sequence 0 then 1.
REQ-041 LSU store, lsu_addr=0x80001000, lsu_wdata=0xDEADBEEF, lsu_wmask=0x0F, mem_req_ready low for 3 cycles -> mem_req_valid held for 4 cycles with fields stable; lsu_resp_valid pulses on the memory ack.
REQ-042 Spurious mem_resp_valid=1 in IDLE and in ISSUE -> no resp_valid asserted; state unchanged.
REQ-043 rst=0 asserted during WAIT -> outputs 0 immediately; a late mem_resp_valid after reset produces no response; a fresh IFU request completes normally.
REQ-044 Continuous IFU and LSU requests for 20 transactions -> strict alternation, no ready overlap, and each response routed only to its owner.
